pio_edge_service_ctrl: RTL
==========================

// Module: pio_edge_service_ctrl
// PURPOSE
//  Avalon-MM master that configures and services one edge-capture input PIO
//  (SET/button-style: 0=data, 2=irq_mask, 3=edge_capture).
//  - After reset, programs the PIO interrupt mask.
//  - On pio_irq: reads edge_capture, clears it and reads the input levels.
//  - Queues {edges, levels} events in a small FIFO for a valid/ready consumer,
//    so the CPU does not poll the PIO.
// PARAMETERS
//  WIDTH       5      PIO input width; must equal the PIO in_port width
//  INIT_MASK   5'h1F  irq_mask value written after every reset
//  FIFO_DEPTH  4      event FIFO entries; power of 2, >=2
// PORTS
//  clk            in   1        single clock, shared with the PIO
//  reset          in   1        asynchronous, active-high
//  avm_address    out  2        PIO register select
//  avm_chipselect out  1        PIO chipselect
//  avm_write_n    out  1        0 = write strobe (with chipselect)
//  avm_writedata  out  32       write data; only [WIDTH-1:0] is meaningful
//  avm_readdata   in   32       PIO readdata; registered, 1-cycle latency
//  pio_irq        in   1        PIO irq (|(edge_capture & irq_mask))
//  enable         in   1        0 = servicing is paused; mask writes still run
//  cfg_mask_wr    in   1        1-cycle pulse: request a new irq_mask
//  cfg_mask       in   WIDTH    new mask; sampled when cfg_mask_wr=1
//  evt_valid      out  1        FIFO not empty
//  evt_ready      in   1        consumer pop; pop happens when valid & ready
//  evt_edges      out  WIDTH    edge bits of the head event
//  evt_level      out  WIDTH    input levels of the head event
//  spurious_cnt   out  8        saturating count of services that read edge_capture=0
// BEHAVIOUR
//  - All avm_* outputs are registered and driven from the FSM state. Idle bus:
//    chipselect=0, write_n=1, address=0, writedata=0.
//  - Reset values: all idle-bus values above, evt_valid=0, spurious_cnt=0,
//    FIFO empty, mask_pend=1 with mask_val=INIT_MASK, FSM in MASK_WR.
//  - States (one cycle each unless stated):
//    MASK_WR: cs=1, write_n=0, addr=2, wdata=mask_val; clear mask_pend; -> IDLE.
//    IDLE: if mask_pend -> MASK_WR; else if pio_irq & enable & !fifo_full
//          -> RD_EDGE; else stay in IDLE.
//    RD_EDGE: cs=1, write_n=1, addr=3 (read).
//    CLR_EDGE: edge_r <= readdata[WIDTH-1:0]; cs=1, write_n=0, addr=3, wdata=0.
//    RD_DATA: cs=1, write_n=1, addr=0.
//    CAP_DATA: lvl_r <= readdata[WIDTH-1:0].
//    PUSH: if edge_r!=0, write {edge_r,lvl_r} to the FIFO; else increment
//          spurious_cnt (saturate at 255); -> IDLE.
//  - Latency: an irq sampled in IDLE at cycle t gives evt_valid=1 at t+6 when
//    the FIFO was empty.
//  - Any write to PIO address 3 clears all capture bits.
//    - Edges arriving between RD_EDGE and CLR_EDGE are lost. This is accepted
//      and documented for software.
//    - Edges arriving while servicing is blocked (full, enable=0) merge in the
//      PIO; the FIFO never overflows.
//  - cfg_mask_wr in any state: mask_val <= cfg_mask, mask_pend <= 1.
//    - The last request wins.
//    - The request is applied at the next IDLE and has priority over servicing.
//  - FIFO full: the FSM holds in IDLE. A push can only happen when space was
//    checked at IDLE entry and the consumer only removes entries, so full is
//    impossible at PUSH.
//  - Simultaneous push and pop are allowed at any occupancy; the count is unchanged.
//  - Reset mid-sequence:
//    - The bus returns to idle immediately and the FIFO is emptied.
//    - The mask is re-programmed with INIT_MASK, not the last cfg_mask.
//  - enable=0 mid-sequence: the current sequence completes; the next one is blocked.
// STRUCTURE
//  - Package pio_ctrl_pkg:
//    - PIO register offsets ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3.
//    - FSM state enum.
//  - One sub-module sync_event_fifo: WIDTH=2*WIDTH, DEPTH=FIFO_DEPTH,
//    show-ahead, full/empty flags.
//  - Top level: FSM, mask request register, capture registers, counter.
// TESTING (bench instantiates the real PIO model)
//  - Reset release: one write of addr=2, data=0x1F; then idle bus;
//    evt_valid=0; PIO irq_mask=0x1F.
//  - Pulse in_port[2] 0->1: one event, edges=0x04, level=0x04, valid 6 cycles
//    after the IDLE irq sample; PIO edge_capture=0 afterwards.
//  - evt_ready=0 and 5 separate edges, FIFO_DEPTH=4: 4 events queued, the 5th
//    held in the PIO (irq stays 1); one pop -> the 5th is serviced.
//  - cfg_mask_wr with 0x01 during RD_DATA: the event completes, then MASK_WR
//    writes 0x01; a later edge on bit 3 produces no service.
//  - Force pio_irq=1 with edge_capture=0: no FIFO push, spurious_cnt=1;
//    256+ repeats saturate at 255.
//  - Assert reset during CLR_EDGE: bus idle next cycle, FIFO empty, MASK_WR
//    with 0x1F after release.

Source files
------------

// File: rtl/pio_edge_service_ctrl_pkg.sv
// Shared definitions for the edge-capture PIO service controller:
// PIO register map, FSM states and the registered bus command.
package pio_ctrl_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    S_MASK_WR,
    S_IDLE,
    S_RD_EDGE,
    S_CLR_EDGE,
    S_RD_DATA,
    S_CAP_DATA,
    S_PUSH
  } state_e;

  typedef struct packed {
    logic       cs;
    logic       write_n;
    logic [1:0] addr;
  } bus_cmd_t;

  localparam bus_cmd_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: ADDR_DATA};

endpackage

// File: rtl/pio_edge_service_ctrl_if.sv
// Avalon-MM link between the service controller and the PIO, plus the PIO irq.
interface pio_edge_service_ctrl_if;
  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        pio_irq;

  modport master (
    output avm_address, avm_chipselect, avm_write_n, avm_writedata,
    input  avm_readdata, pio_irq
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
    output avm_readdata, pio_irq
  );
endinterface

// File: rtl/pio_edge_service_ctrl_fifo.sv
// Show-ahead synchronous FIFO for captured edge events; head is always on rd_data.
module sync_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;
  logic [AW:0]                 count;
  logic                        do_wr, do_rd;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/pio_edge_service_ctrl.sv
// Avalon-MM master that programs a PIO irq mask and, on pio_irq, reads/clears
// edge_capture and reads input levels, queueing {edges, levels} events.
module pio_edge_service_ctrl
  import pio_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 5,
  parameter logic [WIDTH-1:0] INIT_MASK  = WIDTH'(5'h1F),
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  pio_edge_service_ctrl_if.master bus,
  input  logic                   enable,
  input  logic                   cfg_mask_wr,
  input  logic [WIDTH-1:0]       cfg_mask,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [WIDTH-1:0]       evt_edges,
  output logic [WIDTH-1:0]       evt_level,
  output logic [7:0]             spurious_cnt
);
  state_e             state, state_nxt;
  bus_cmd_t           cmd_nxt;
  logic [31:0]        wdata_nxt;
  logic               mask_pend;
  logic [WIDTH-1:0]   mask_val, edge_r, lvl_r;
  logic               fifo_full, fifo_empty, push;
  logic [2*WIDTH-1:0] fifo_rd;
  logic               unused_rdata;

  assign unused_rdata = ^bus.avm_readdata[31:WIDTH];

  // Bus registers load from the next state, so each state's command is on the
  // bus during that state. Right after reset the bus is still idle, hence
  // MASK_WR waits one cycle for its write strobe to appear.
  always_comb begin
    state_nxt = state;
    case (state)
      S_MASK_WR:  if (bus.avm_chipselect) state_nxt = S_IDLE;
      S_IDLE: begin
        if (mask_pend)                                 state_nxt = S_MASK_WR;
        else if (bus.pio_irq && enable && !fifo_full) state_nxt = S_RD_EDGE;
      end
      S_RD_EDGE:  state_nxt = S_CLR_EDGE;
      S_CLR_EDGE: state_nxt = S_RD_DATA;
      S_RD_DATA:  state_nxt = S_CAP_DATA;
      S_CAP_DATA: state_nxt = S_PUSH;
      S_PUSH:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase

    cmd_nxt   = BUS_IDLE;
    wdata_nxt = '0;
    case (state_nxt)
      S_MASK_WR: begin
        cmd_nxt   = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_MASK};
        wdata_nxt = 32'(mask_val);
      end
      S_RD_EDGE:  cmd_nxt = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_EDGE};
      S_CLR_EDGE: cmd_nxt = '{cs: 1'b1, write_n: 1'b0, addr: ADDR_EDGE};
      S_RD_DATA:  cmd_nxt = '{cs: 1'b1, write_n: 1'b1, addr: ADDR_DATA};
      default:    cmd_nxt = BUS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= S_MASK_WR;
      bus.avm_chipselect <= 1'b0;
      bus.avm_write_n    <= 1'b1;
      bus.avm_address    <= ADDR_DATA;
      bus.avm_writedata  <= '0;
    end else begin
      state              <= state_nxt;
      bus.avm_chipselect <= cmd_nxt.cs;
      bus.avm_write_n    <= cmd_nxt.write_n;
      bus.avm_address    <= cmd_nxt.addr;
      bus.avm_writedata  <= wdata_nxt;
    end
  end

  // A new mask request beats the clear, so a request landing during the
  // write itself is re-issued with the newest value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_pend    <= 1'b1;
      mask_val     <= INIT_MASK;
      edge_r       <= '0;
      lvl_r        <= '0;
      spurious_cnt <= '0;
    end else begin
      if (cfg_mask_wr) begin
        mask_pend <= 1'b1;
        mask_val  <= cfg_mask;
      end else if (state == S_MASK_WR && bus.avm_chipselect) begin
        mask_pend <= 1'b0;
      end
      if (state == S_CLR_EDGE) edge_r <= bus.avm_readdata[WIDTH-1:0];
      if (state == S_CAP_DATA) lvl_r  <= bus.avm_readdata[WIDTH-1:0];
      if (state == S_PUSH && edge_r == '0 && spurious_cnt != 8'hFF)
        spurious_cnt <= spurious_cnt + 8'd1;
    end
  end

  assign push = (state == S_PUSH) && (edge_r != '0);

  sync_event_fifo #(.WIDTH(2*WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data ({edge_r, lvl_r}),
    .rd_en   (evt_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid              = !fifo_empty;
  assign {evt_edges, evt_level} = fifo_rd;
endmodule
